// File: rtl/pll_lock_supervisor.sv
// Supervises an ECP5 EHXPLLL: pulses its RST, qualifies LOCK, then releases
// downstream domain resets one by one. Runs on the PLL reference clock.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 32,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_STABLE    = 1024,
  parameter int RELEASE_GAP    = 16,
  parameter int NUM_DOMAINS    = 3,
  parameter int CNT_W          = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   locked,
  input  logic                   clear_counts,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready,
  output logic [CNT_W-1:0]       lost_count,
  output logic [CNT_W-1:0]       timeout_count
);

  // One shared timer serves the reset pulse, lock timeout, stable count and release gap.
  localparam int MAX_AB = (LOCK_TIMEOUT > LOCK_STABLE + 1) ? LOCK_TIMEOUT : LOCK_STABLE + 1;
  localparam int MAX_CD = (PLL_RST_CYCLES > RELEASE_GAP) ? PLL_RST_CYCLES : RELEASE_GAP;
  localparam int MAXV   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW     = $clog2(MAXV + 1);

  localparam logic [TW-1:0] RST_LAST  = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_N  = TW'(LOCK_STABLE);
  localparam logic [TW-1:0] GAP_LAST  = TW'(RELEASE_GAP - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       lost_q, timeout_q;
  logic                   lost_inc, timeout_inc;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [NUM_DOMAINS-1:0] rst_shift;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign rst_shift = rst_out_q << 1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= PLL_RESET;
      timer_q   <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pll_rst_d   = pll_rst_q;
    rst_out_d   = rst_out_q;
    ready_d     = ready_q;
    lost_inc    = 1'b0;
    timeout_inc = 1'b0;
    case (state_q)
      PLL_RESET: begin
        pll_rst_d = 1'b1;
        rst_out_d = '1;
        ready_d   = 1'b0;
        if (timer_q == RST_LAST) begin
          state_d   = WAIT_LOCK;
          timer_d   = '0;
          pll_rst_d = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        // Lock is checked first so it wins over a coincident timeout.
        if (lock_s) begin
          state_d = STABLE;
          timer_d = TIMER_ONE;
        end else if (timer_q == TMO_LAST) begin
          state_d     = PLL_RESET;
          timer_d     = '0;
          pll_rst_d   = 1'b1;
          timeout_inc = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STABLE_N) begin
          timer_d   = '0;
          rst_out_d = rst_shift;
          if (rst_shift == '0) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d   = PLL_RESET;
          timer_d   = '0;
          pll_rst_d = 1'b1;
          rst_out_d = '1;
          ready_d   = 1'b0;
          lost_inc  = 1'b1;
        end else if (timer_q == GAP_LAST) begin
          timer_d   = '0;
          rst_out_d = rst_shift;
          if (rst_shift == '0) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d   = PLL_RESET;
          timer_d   = '0;
          pll_rst_d = 1'b1;
          rst_out_d = '1;
          ready_d   = 1'b0;
          lost_inc  = 1'b1;
        end
      end
      default: begin
        state_d   = PLL_RESET;
        timer_d   = '0;
        pll_rst_d = 1'b1;
        rst_out_d = '1;
        ready_d   = 1'b0;
      end
    endcase
  end

  // Event counters saturate; a clear request overrides any increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lost_q    <= '0;
      timeout_q <= '0;
    end else if (clear_counts) begin
      lost_q    <= '0;
      timeout_q <= '0;
    end else begin
      if (lost_inc && (lost_q != '1)) begin
        lost_q <= lost_q + 1'b1;
      end
      if (timeout_inc && (timeout_q != '1)) begin
        timeout_q <= timeout_q + 1'b1;
      end
    end
  end

  assign pll_rst       = pll_rst_q;
  assign rst_out       = rst_out_q;
  assign ready         = ready_q;
  assign lost_count    = lost_q;
  assign timeout_count = timeout_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Consumer side of the ECP5 EHXPLLL lock interface. It drives the PLL RST input and watches its asynchronous LOCK output. It holds the downstream clock domains in reset until lock has been stable, then releases the per-domain resets in a fixed order. It re-cycles the PLL on lock timeout or lock loss, and counts both events. Runs on the free-running board oscillator, i.e. the PLL reference clock, never on a PLL output.

Parameters:
SYNC_STAGES, 2, flops in the `locked` synchroniser (>=2)
PLL_RST_CYCLES, 32, cycles `pll_rst` is held high per PLL reset pulse (>=1)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before re-resetting the PLL (>=2)
LOCK_STABLE, 1024, consecutive synchronised-lock cycles required before release (>=2)
RELEASE_GAP, 16, cycles between successive domain reset releases (>=1)
NUM_DOMAINS, 3, number of downstream reset outputs (1..8)
CNT_W, 8, width of the event counters

Ports:
clock  in  1  free-running reference clock (board 25 MHz)
reset_n  in  1  asynchronous, active-low reset
locked  in  1  PLL LOCK output; asynchronous to `clock`
clear_counts  in  1  synchronous; zeroes both counters
pll_rst  out  1  to PLL RST, active-high
rst_out  out  NUM_DOMAINS  per-domain active-high resets; bit 0 is released first
ready  out  1  high when all domains are released and lock holds
lost_count  out  CNT_W  saturating count of lock losses after stable lock was reached
timeout_count  out  CNT_W  saturating count of WAIT_LOCK timeouts

Behaviour:
- `reset_n` low, asynchronous:
  - state = PLL_RESET.
  - `pll_rst` = 1, `rst_out` = all ones, `ready` = 0.
  - Counters = 0, timers = 0, synchroniser = 0.
- `lock_s` is the last stage of a SYNC_STAGES flop chain on `locked`. No other logic samples `locked` directly.
- All outputs are registered.
- PLL_RESET:
  - `pll_rst` = 1, `rst_out` = all ones, `ready` = 0. `lock_s` is ignored.
  - After PLL_RST_CYCLES cycles, go to WAIT_LOCK with the timer cleared; `pll_rst` drops on that edge.
- WAIT_LOCK:
  - Timer increments every cycle.
  - `lock_s` = 1: go to STABLE with stable count = 1.
  - Timer reaches LOCK_TIMEOUT-1 with `lock_s` = 0: `timeout_count` += 1 (saturating), go to PLL_RESET.
  - If lock and timeout occur in the same cycle, lock wins.
- STABLE:
  - Stable count increments while `lock_s` = 1.
  - `lock_s` = 0: go to WAIT_LOCK with the timer cleared. No counter change; this is a glitch, not a loss.
  - Count reaches LOCK_STABLE: go to RELEASE and clear `rst_out[0]` on the same edge.
- Release timing:
  - With `locked` steady from the edge E where it is first sampled high (state already WAIT_LOCK), `rst_out[0]` falls at edge E+SYNC_STAGES+LOCK_STABLE.
  - `rst_out[k]` falls RELEASE_GAP cycles after `rst_out[k-1]`.
  - `ready` rises on the same edge that `rst_out[NUM_DOMAINS-1]` falls; state becomes RUN.
  - NUM_DOMAINS = 1: `rst_out[0]` and `ready` change together, going STABLE directly to RUN.
- Lock loss in RELEASE or RUN (`lock_s` = 0):
  - On the next edge: `rst_out` = all ones, `ready` = 0, `lost_count` += 1 (saturating), state = PLL_RESET, `pll_rst` = 1.
- Counters:
  - Both saturate at 2^CNT_W-1.
  - `clear_counts` zeroes both and wins over a simultaneous increment.
  - Counters do not change on any state transition other than those listed above.
- `rst_out` bits only ever change in two ways: release in order 0 to N-1, and assertion all together. No other pattern is legal.

Test Plan:
Bench parameters: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, RELEASE_GAP=4, NUM_DOMAINS=3, CNT_W=2. Cycle numbers count edges after `reset_n` is released.
1. Clean lock, `locked` high from edge 10:
   - `pll_rst` is high for edges 0-3, low from edge 4.
   - `rst_out[0]` falls at edge 20, `rst_out[1]` at 24, `rst_out[2]` at 28; `ready` rises at 28.
   - Both counters stay 0.
2. `locked` held low:
   - `pll_rst` pulses 4 cycles every 36 cycles.
   - `timeout_count` reads 1, 2, 3, then stays 3 (saturated).
   - `rst_out` stays 3'b111 throughout.
3. Glitch: `locked` high for 5 cycles, then low for 1, then high steady:
   - No release during the glitch; the stable count restarts.
   - `rst_out[0]` falls 10 cycles after `locked` is sampled high the final time.
   - `lost_count` = 0.
4. Loss in RUN: after `ready` = 1, drop `locked`:
   - Within 3 edges, `rst_out` = 3'b111, `ready` = 0, `pll_rst` = 1, `lost_count` = 1.
   - Re-raising `locked` repeats the scenario 1 release sequence.
5. Loss mid-release: drop `locked` after `rst_out[0]` falls but before `rst_out[1]` falls:
   - All bits re-assert; `lost_count` += 1.
   - Assert `clear_counts` on the increment edge: both counters read 0.
6. Assert `reset_n` low in RELEASE between clock edges:
   - Immediately, with no clock edge: `rst_out` = 3'b111, `pll_rst` = 1, `ready` = 0, counters = 0.
